// File: rtl/go_pkg.sv
// Shared types for the Go board controller and the board renderer.
// Cell encodings, board geometry and the controller state type.
package go_pkg;

    localparam int BOARD_N = 9;
    localparam logic [3:0] CENTER = 4'd4;

    typedef enum logic [1:0] {
        EMPTY  = 2'b00,
        BLACK  = 2'b01,
        WHITE  = 2'b10,
        CURSOR = 2'b11
    } cell_t;

    typedef logic [0:BOARD_N-1][0:BOARD_N-1][1:0] board_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CHECK,
        S_WRITE,
        S_CLEAR
    } ctrl_state_t;

    function automatic logic [3:0] wrap_inc(input logic [3:0] v);
        return (v == 4'(BOARD_N - 1)) ? 4'd0 : v + 4'd1;
    endfunction

    function automatic logic [3:0] wrap_dec(input logic [3:0] v);
        return (v == 4'd0) ? 4'(BOARD_N - 1) : v - 4'd1;
    endfunction

endpackage

// File: rtl/go_cursor.sv
// Cursor position: row/column counters that wrap modulo the board size.
// The caller guarantees at most one move pulse per cycle; home wins over moves.
module go_cursor
    import go_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       home,
    input  logic       up,
    input  logic       down,
    input  logic       left,
    input  logic       right,
    output logic [3:0] row,
    output logic [3:0] col
);

    logic [3:0] row_q, row_d;
    logic [3:0] col_q, col_d;

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (home) begin
            row_d = CENTER;
            col_d = CENTER;
        end else begin
            if (up)
                row_d = wrap_dec(row_q);
            else if (down)
                row_d = wrap_inc(row_q);
            if (left)
                col_d = wrap_dec(col_q);
            else if (right)
                col_d = wrap_inc(col_q);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            row_q <= CENTER;
            col_q <= CENTER;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    assign row = row_q;
    assign col = col_q;

endmodule

// File: rtl/go_board_ctrl.sv
// 9x9 Go game-state controller: stone array, turn, passes and clears, plus a
// once-per-frame board snapshot with a blinking cursor for the renderer.
module go_board_ctrl
    import go_pkg::*;
#(
    parameter int BLINK_FRAMES = 30
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    btn_up,
    input  logic                    btn_down,
    input  logic                    btn_left,
    input  logic                    btn_right,
    input  logic                    btn_place,
    input  logic                    btn_pass,
    input  logic                    btn_clear,
    input  logic                    frame_start,
    output logic [0:8][0:8][1:0]    board,
    output logic [3:0]              cursor_row,
    output logic [3:0]              cursor_col,
    output logic                    turn,
    output logic [6:0]              move_count,
    output logic                    game_over,
    output logic                    illegal,
    output logic                    busy
);

    localparam int CNT_W = $clog2(BLINK_FRAMES + 1);

    ctrl_state_t       state_q, state_d;
    board_t            stones_q, stones_d;
    board_t            board_q, board_d;
    logic              turn_q, turn_d;
    logic [6:0]        move_count_q, move_count_d;
    logic [1:0]        pass_streak_q, pass_streak_d;
    logic              game_over_q, game_over_d;
    logic              illegal_q, illegal_d;
    logic [3:0]        clr_row_q, clr_row_d;
    logic [3:0]        clr_col_q, clr_col_d;
    logic [CNT_W-1:0]  blink_cnt_q, blink_cnt_d;
    logic              blink_phase_q, blink_phase_d;

    logic       mv_up, mv_down, mv_left, mv_right, cur_home;
    logic [3:0] cur_row, cur_col;

    go_cursor u_cursor (
        .clk     (clk),
        .reset_n (reset_n),
        .home    (cur_home),
        .up      (mv_up),
        .down    (mv_down),
        .left    (mv_left),
        .right   (mv_right),
        .row     (cur_row),
        .col     (cur_col)
    );

    always_comb begin
        state_d       = state_q;
        stones_d      = stones_q;
        turn_d        = turn_q;
        move_count_d  = move_count_q;
        pass_streak_d = pass_streak_q;
        game_over_d   = game_over_q;
        illegal_d     = 1'b0;
        clr_row_d     = clr_row_q;
        clr_col_d     = clr_col_q;
        mv_up         = 1'b0;
        mv_down       = 1'b0;
        mv_left       = 1'b0;
        mv_right      = 1'b0;
        cur_home      = 1'b0;

        // Clear pre-empts everything, including an in-flight placement.
        if (btn_clear) begin
            state_d   = S_CLEAR;
            clr_row_d = 4'd0;
            clr_col_d = 4'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (btn_place) begin
                        if (!game_over_q)
                            state_d = S_CHECK;
                    end else if (btn_pass) begin
                        if (!game_over_q) begin
                            turn_d        = ~turn_q;
                            pass_streak_d = (pass_streak_q == 2'd2) ? 2'd2 : pass_streak_q + 2'd1;
                            if (pass_streak_q != 2'd0)
                                game_over_d = 1'b1;
                        end
                    end else begin
                        mv_up    = btn_up;
                        mv_down  = btn_down & ~btn_up;
                        mv_left  = btn_left & ~btn_up & ~btn_down;
                        mv_right = btn_right & ~btn_up & ~btn_down & ~btn_left;
                    end
                end
                // The cell read and the commit/reject decision share one cycle,
                // so the stone lands on the second edge after the place pulse.
                S_CHECK: begin
                    state_d = S_IDLE;
                    if (stones_q[cur_row][cur_col] != EMPTY) begin
                        illegal_d = 1'b1;
                    end else begin
                        stones_d[cur_row][cur_col] = turn_q ? WHITE : BLACK;
                        turn_d        = ~turn_q;
                        move_count_d  = move_count_q + 7'd1;
                        pass_streak_d = 2'd0;
                    end
                end
                S_CLEAR: begin
                    stones_d[clr_row_q][clr_col_q] = EMPTY;
                    if (clr_col_q == 4'(BOARD_N - 1)) begin
                        clr_col_d = 4'd0;
                        clr_row_d = clr_row_q + 4'd1;
                    end else begin
                        clr_col_d = clr_col_q + 4'd1;
                    end
                    if (clr_row_q == 4'(BOARD_N - 1) && clr_col_q == 4'(BOARD_N - 1)) begin
                        state_d       = S_IDLE;
                        cur_home      = 1'b1;
                        turn_d        = 1'b0;
                        move_count_d  = 7'd0;
                        pass_streak_d = 2'd0;
                        game_over_d   = 1'b0;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Snapshot path: samples the pre-commit array so a same-edge commit waits a frame.
    always_comb begin
        board_d       = board_q;
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        if (frame_start) begin
            board_d = stones_q;
            if (blink_phase_q)
                board_d[cur_row][cur_col] = CURSOR;
            if (blink_cnt_q == CNT_W'(BLINK_FRAMES - 1)) begin
                blink_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            stones_q      <= '0;
            board_q       <= '0;
            turn_q        <= 1'b0;
            move_count_q  <= 7'd0;
            pass_streak_q <= 2'd0;
            game_over_q   <= 1'b0;
            illegal_q     <= 1'b0;
            clr_row_q     <= 4'd0;
            clr_col_q     <= 4'd0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b1;
        end else begin
            state_q       <= state_d;
            stones_q      <= stones_d;
            board_q       <= board_d;
            turn_q        <= turn_d;
            move_count_q  <= move_count_d;
            pass_streak_q <= pass_streak_d;
            game_over_q   <= game_over_d;
            illegal_q     <= illegal_d;
            clr_row_q     <= clr_row_d;
            clr_col_q     <= clr_col_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
        end
    end

    assign board      = board_q;
    assign cursor_row = cur_row;
    assign cursor_col = cur_col;
    assign turn       = turn_q;
    assign move_count = move_count_q;
    assign game_over  = game_over_q;
    assign illegal    = illegal_q;
    assign busy       = (state_q != S_IDLE);

endmodule
